// File: rtl/wb_burst_master.sv
// wb_burst_master: one-shot request to Wishbone B4 pipelined single/incrementing-burst master.
// Optional idle-ACK watchdog compiled in with `define WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master #(
  parameter int LEN_W = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             CLK,
  input  logic             RST_SYNC,
  input  logic             EN,
  input  logic             REQ_IN,
  output logic             REQ_RDY_OUT,
  input  logic [31:0]      REQ_ADR_IN,
  input  logic             REQ_WE_IN,
  input  logic [3:0]       REQ_SEL_IN,
  input  logic [LEN_W-1:0] REQ_LEN_IN,
  input  logic [31:0]      WR_DAT_IN,
  output logic             WR_DAT_POP_OUT,
  output logic [31:0]      RD_DAT_OUT,
  output logic             RD_VALID_OUT,
  output logic             DONE_OUT,
  output logic             ERR_OUT,
  output logic [31:0]      WB_ADR_OUT,
  output logic             WB_CYC_OUT,
  output logic             WB_STB_OUT,
  output logic             WB_WE_OUT,
  output logic [3:0]       WB_SEL_OUT,
  output logic [2:0]       WB_CTI_OUT,
  output logic [1:0]       WB_BTE_OUT,
  output logic [31:0]      WB_WR_DAT_OUT,
  input  logic             WB_STALL_IN,
  input  logic             WB_ACK_IN,
  input  logic             WB_ERR_IN,
  input  logic [31:0]      WB_RD_DAT_IN
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;
  state_t state, nxt;
  logic [31:0] adr, rd_dat;
  logic [3:0] sel;
  logic [LEN_W-1:0] len, issue_cnt, ack_cnt;
  logic we, err_flag, rd_valid;
  logic cyc, stb, beat, ack, err, last_beat, acks_done;
  assign cyc = state == ISSUE || state == WAIT_ACK;
  assign stb = state == ISSUE;
  assign beat = stb & ~WB_STALL_IN;
  assign last_beat = issue_cnt == len - LEN_W'(1);
  // ERR beats a simultaneous ACK: that response is neither counted nor returned
  assign ack = cyc & WB_ACK_IN & ~err;
  assign acks_done = ack_cnt + LEN_W'(ack) == len;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;
  assign err = cyc & (WB_ERR_IN | wd == WD_W'(TIMEOUT_CYC));
  always_ff @(posedge CLK)
    if (RST_SYNC) wd <= '0;
    else if (EN) wd <= (!cyc || WB_ACK_IN || WB_ERR_IN || beat) ? '0 : wd + WD_W'(1);
`else
  assign err = cyc & WB_ERR_IN;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:           nxt = REQ_IN ? (REQ_LEN_IN == '0 ? DONE : ISSUE) : IDLE;
      ISSUE, WAIT_ACK: nxt = (err || acks_done) ? DONE : (stb && beat && last_beat) ? WAIT_ACK : state;
      default:        nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state <= IDLE;
      adr <= '0;
      we <= 1'b0;
      sel <= '0;
      len <= '0;
      issue_cnt <= '0;
      ack_cnt <= '0;
      err_flag <= 1'b0;
      rd_dat <= '0;
      rd_valid <= 1'b0;
    end else if (EN) begin
      state <= nxt;
      rd_valid <= ack & ~we;
      if (ack && !we) rd_dat <= WB_RD_DAT_IN;
      if (state == IDLE && REQ_IN) begin
        adr <= REQ_ADR_IN & ~32'h3;
        we <= REQ_WE_IN;
        sel <= REQ_SEL_IN;
        len <= REQ_LEN_IN;
        issue_cnt <= '0;
        ack_cnt <= '0;
        err_flag <= REQ_LEN_IN == '0;
      end else begin
        if (beat) adr <= adr + 32'd4;
        if (beat) issue_cnt <= issue_cnt + LEN_W'(1);
        if (ack) ack_cnt <= ack_cnt + LEN_W'(1);
        if (err) err_flag <= 1'b1;
      end
    end
  end
  assign REQ_RDY_OUT = state == IDLE;
  assign WR_DAT_POP_OUT = beat & we & EN;
  assign RD_DAT_OUT = rd_dat;
  assign RD_VALID_OUT = rd_valid;
  assign DONE_OUT = state == DONE;
  assign ERR_OUT = DONE_OUT & err_flag;
  assign WB_ADR_OUT = adr;
  assign WB_CYC_OUT = cyc;
  assign WB_STB_OUT = stb;
  assign WB_WE_OUT = we;
  assign WB_SEL_OUT = sel;
  assign WB_CTI_OUT = !stb ? 3'b000 : len == LEN_W'(1) ? 3'b000 : last_beat ? 3'b111 : 3'b010;
  assign WB_BTE_OUT = 2'b00;
  assign WB_WR_DAT_OUT = WR_DAT_IN;
endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Converts a simple one-shot request port into Wishbone B4 pipelined-mode master cycles: single transfers or linear incrementing bursts.
It is the standard master front-end that feeds one WB_SL*_ port of the 4-master/1-slave arbiter. The arbiter holds STALL high until grant, so this block treats STALL as both grant and flow control.
One request owns the bus (CYC held) from the first beat until the last ACK or an ERR.

Parameters:
LEN_W, 4, width of the beat-count field; legal burst lengths are 1..(2^LEN_W - 1).
TIMEOUT_CYC, 255, idle-ACK watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
CLK  in  1  single clock; all logic is on the rising edge.
RST_SYNC  in  1  synchronous reset, active-high.
EN  in  1  clock enable; when low, all registers hold.
REQ_IN  in  1  request valid.
REQ_RDY_OUT  out  1  high only in IDLE; a request is accepted on REQ_IN & REQ_RDY_OUT & EN.
REQ_ADR_IN  in  32  byte start address; bits [1:0] are ignored and forced to 0.
REQ_WE_IN  in  1  1 = write, 0 = read.
REQ_SEL_IN  in  4  byte select, applied to every beat.
REQ_LEN_IN  in  LEN_W  beat count.
WR_DAT_IN  in  32  current write beat from a show-ahead source.
WR_DAT_POP_OUT  out  1  write beat consumed this cycle; the source advances.
RD_DAT_OUT  out  32  registered read data.
RD_VALID_OUT  out  1  RD_DAT_OUT is valid; one pulse per read beat.
DONE_OUT  out  1  one-cycle pulse at the end of every accepted request.
ERR_OUT  out  1  qualifies DONE_OUT; the request failed.
WB_ADR_OUT, WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT  out  32,1,1,1  Wishbone master signals.
WB_SEL_OUT, WB_CTI_OUT, WB_BTE_OUT, WB_WR_DAT_OUT  out  4,3,2,32  Wishbone master signals.
WB_STALL_IN, WB_ACK_IN, WB_ERR_IN  in  1,1,1  Wishbone slave responses.
WB_RD_DAT_IN  in  32  Wishbone read data.

Behaviour:
- Reset values: every output is 0, except REQ_RDY_OUT = 1. State = IDLE, all counters = 0.
- States: IDLE -> ISSUE -> WAIT_ACK -> DONE -> IDLE.
- IDLE, request accepted:
  - Latch address, WE, SEL and LEN.
  - If LEN == 0: go to DONE with the error flag set. No bus cycle is generated.
  - Otherwise: go to ISSUE. CYC and STB rise on the next cycle.
- ISSUE:
  - CYC = 1, STB = 1.
  - A beat is accepted when STB & !STALL. On each accepted beat, ADR += 4 (mod 2^32, wrap allowed) and issue_cnt increments.
  - After the last beat is accepted, STB = 0 and the state goes to WAIT_ACK. If that beat's ACK is already present, go straight to DONE.
- CTI per beat:
  - LEN == 1: 000.
  - LEN > 1: 010 on non-last beats, 111 on the last beat.
  - BTE is always 00.
- Write data:
  - WB_WR_DAT_OUT = WR_DAT_IN, combinational.
  - WR_DAT_POP_OUT = STB & !STALL & WE.
- ACK handling:
  - ACKs are counted in ack_cnt in any state where CYC = 1; ACKs may arrive during ISSUE.
  - Up to LEN beats may be outstanding.
  - ACKs received while CYC = 0 are ignored.
- Read data: on each ACK of a read, RD_DAT_OUT <= WB_RD_DAT_IN and RD_VALID_OUT pulses the following cycle.
- WAIT_ACK: CYC = 1, STB = 0. Exit to DONE on the edge where ack_cnt reaches LEN.
- DONE:
  - CYC = 0, DONE_OUT = 1, ERR_OUT = error flag. Lasts one cycle, then IDLE.
  - The last RD_VALID_OUT coincides with DONE_OUT.
- ERR (from ISSUE or WAIT_ACK):
  - Set the error flag and go to DONE. CYC and STB drop on the next cycle.
  - Remaining beats are abandoned and no further POPs occur.
  - ACK and ERR in the same cycle: ERR wins; the beat is not counted and RD_VALID_OUT is not pulsed.
- Back-to-back requests: at least 2 idle bus cycles between the last ACK and the next CYC (the DONE and IDLE cycles).
- EN low: state, counters and all registered outputs hold. Combinational outputs follow their held inputs.
- RST_SYNC mid-burst: on the next edge, all outputs return to their reset values. Outstanding ACKs are ignored because CYC = 0. No DONE_OUT is generated.

Optional Feature:
WB_BURST_MASTER_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on any ACK, ERR or beat acceptance, and counts while CYC = 1.
  - When it reaches TIMEOUT_CYC, the block behaves exactly as on WB_ERR_IN: DONE_OUT and ERR_OUT pulse and CYC drops.
  - A stall during arbitration also counts.
- Not defined: no counter is built; the block waits indefinitely for ACK/ERR.

Test Plan:
- Single read, LEN=1, ADR=0x1000_0003, slave ACKs 1 cycle after STB with 0xDEAD_BEEF:
  - Bus: ADR=0x1000_0000, CTI=000.
  - Then RD_VALID_OUT with 0xDEAD_BEEF, simultaneous with DONE_OUT; ERR_OUT=0.
- Write burst, LEN=4, ADR=0x2000_0000, STALL=1 for 3 cycles then 0, ACK on each accepted beat:
  - Addresses 0x..00, 04, 08, 0C; CTI 010, 010, 010, 111.
  - Exactly 4 POPs; DONE_OUT follows the 4th ACK.
- Read burst, LEN=3, slave stalls on beat 2 and delays ACKs by 2 cycles:
  - 3 RD_VALID_OUT pulses, in order, with data matching.
  - CYC stays high until the 3rd ACK.
- Read burst, LEN=4, ERR on the 2nd response (same cycle as ACK):
  - 1 RD_VALID_OUT only.
  - CYC drops on the next cycle; DONE_OUT=1 and ERR_OUT=1.
- Edge cases:
  - ADR=0xFFFF_FFFC, LEN=2: second beat address is 0x0000_0000.
  - LEN=0: DONE_OUT and ERR_OUT with CYC never asserted.
- RST_SYNC asserted mid-burst (after beat 2 of 4):
  - On the next cycle, CYC=STB=0 and REQ_RDY_OUT=1; no DONE_OUT.
  - With WB_BURST_MASTER_TIMEOUT_EN and TIMEOUT_CYC=16, a slave that never ACKs gives ERR_OUT after 16 cycles.
